// File: rtl/sync_bank.sv
`default_nettype none
// ============================================================================
// Module      : sync_bank
// Description : Multi-channel single-bit synchronizer bank. Each channel runs
//               through a STAGES-deep flop chain and an optional stability
//               filter (compiled in when SYNC_FILTER_EN is defined). Each
//               channel produces a registered level plus one-cycle rise and
//               fall pulses.
// Revision    : 1.0 - initial release, successor to the fixed two-flop
//               pointer synchronizer
// ============================================================================
module sync_bank #(
   parameter int                  CHANNELS   = 4,
   parameter int                  STAGES     = 2,
   parameter logic [CHANNELS-1:0] RST_VAL    = {CHANNELS{1'b0}},
   parameter int                  FILTER_LEN = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] async_in,
   output logic [CHANNELS-1:0] sync_out,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic                any_edge
);

   // Parameter legality, rejected at elaboration time.
   if (CHANNELS < 1) begin : g_chk_channels
      $error("sync_bank: CHANNELS must be at least 1");
   end
   if (STAGES < 2) begin : g_chk_stages
      $error("sync_bank: STAGES must be at least 2");
   end
   if (FILTER_LEN < 1) begin : g_chk_filter_len
      $error("sync_bank: FILTER_LEN must be at least 1");
   end

   logic [CHANNELS-1:0] stage_q [STAGES];
   logic [CHANNELS-1:0] tail;
   logic [CHANNELS-1:0] hist_q;

   // Synchronizer chain: stage 0 samples the asynchronous inputs, later stages
   // give metastability time to resolve.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++) begin
            stage_q[s] <= RST_VAL;
         end
      end else begin
         stage_q[0] <= async_in;
         for (int s = 1; s < STAGES; s++) begin
            stage_q[s] <= stage_q[s-1];
         end
      end
   end

   assign tail = stage_q[STAGES-1];

`ifdef SYNC_FILTER_EN
   localparam int                CNT_W    = $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic [CHANNELS-1:0] filt_q;
   logic [CHANNELS-1:0] filt_d;
   logic [CNT_W-1:0]    cnt_q [CHANNELS];
   logic [CNT_W-1:0]    cnt_d [CHANNELS];

   // Filter next state: a channel only follows the tail once the tail has
   // disagreed with it for FILTER_LEN consecutive cycles; any agreement
   // restarts the count.
   always_comb begin
      filt_d = filt_q;
      for (int c = 0; c < CHANNELS; c++) begin
         cnt_d[c] = cnt_q[c];
         if (tail[c] == filt_q[c]) begin
            cnt_d[c] = '0;
         end else if (cnt_q[c] == CNT_LAST) begin
            filt_d[c] = tail[c];
            cnt_d[c]  = '0;
         end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
         end
      end
   end

   // Filter state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q <= RST_VAL;
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c] <= '0;
         end
      end else begin
         filt_q <= filt_d;
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c] <= cnt_d[c];
         end
      end
   end

   assign sync_out = filt_q;
`else
   assign sync_out = tail;
`endif

   // Edge history: previous cycle's output level, used for pulse generation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= RST_VAL;
      end else begin
         hist_q <= sync_out;
      end
   end

   // Pulses are derived purely from registers, so they are glitch-free.
   assign rise_pulse = sync_out & ~hist_q;
   assign fall_pulse = ~sync_out & hist_q;
   assign any_edge   = |(rise_pulse | fall_pulse);

endmodule
`default_nettype wire

// File: tb/tb_sync_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sync_bank
// Description : Self-checking bench for sync_bank. Two instances: A (4 ch,
//               2 stages, reset 0, filter length 4) and B (3 ch, 3 stages,
//               reset 3'b101, filter length 1). Honours SYNC_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_bank;

   localparam int         A_ST  = 2;
   localparam int         A_FL  = 4;
   localparam logic [3:0] A_RST = 4'b0000;
   localparam int         B_ST  = 3;
   localparam int         B_FL  = 1;
   localparam logic [2:0] B_RST = 3'b101;
`ifdef SYNC_FILTER_EN
   localparam int LAT_A = A_ST + A_FL;
   localparam int LAT_B = B_ST + B_FL;
`else
   localparam int LAT_A = A_ST;
   localparam int LAT_B = B_ST;
`endif
   localparam int LOGN = 1024;
   localparam int NVEC = 24;

   logic       clk;
   logic       rst;
   logic [3:0] ain_a;
   logic [2:0] ain_b;
   logic [3:0] sync_a, rise_a, fall_a;
   logic       any_a;
   logic [2:0] sync_b, rise_b, fall_b;
   logic       any_b;

   int checks;
   int errors;

   sync_bank #(.CHANNELS(4), .STAGES(A_ST), .RST_VAL(A_RST), .FILTER_LEN(A_FL)) dut_a (
      .clk(clk), .rst(rst), .async_in(ain_a), .sync_out(sync_a),
      .rise_pulse(rise_a), .fall_pulse(fall_a), .any_edge(any_a)
   );

   sync_bank #(.CHANNELS(3), .STAGES(B_ST), .RST_VAL(B_RST), .FILTER_LEN(B_FL)) dut_b (
      .clk(clk), .rst(rst), .async_in(ain_b), .sync_out(sync_b),
      .rise_pulse(rise_b), .fall_pulse(fall_b), .any_edge(any_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   // ------------------------------------------------------------------
   // Reference model. Levels are indexed by edge count since reset:
   // the tail after edge n is the input sampled at edge n-STAGES+1.
   // The filtered level flips once the last FILTER_LEN tail values all
   // disagree with it.
   // ------------------------------------------------------------------
   logic [3:0] log_a [LOGN];
   logic [3:0] log_b [LOGN];
   int         n_m;
   logic [3:0] ms_a, mp_a, ms_b, mp_b;

   function automatic logic [3:0] tail_of(input bit is_b, input int m);
      int st;
      int idx;
      st  = is_b ? B_ST : A_ST;
      idx = m - st + 1;
      if (idx < 1) return is_b ? {1'b0, B_RST} : A_RST;
      return is_b ? log_b[idx % LOGN] : log_a[idx % LOGN];
   endfunction

   function automatic logic [3:0] filt_next(input bit is_b, input logic [3:0] cur);
      int         fl;
      logic [3:0] nx;
      logic [3:0] t;
      bit         all_diff;
      fl = is_b ? B_FL : A_FL;
      nx = cur;
      for (int c = 0; c < 4; c++) begin
         all_diff = 1'b1;
         for (int j = 0; j < fl; j++) begin
            t = tail_of(is_b, n_m - j);
            if (t[c] == cur[c]) all_diff = 1'b0;
         end
         if (all_diff) nx[c] = ~cur[c];
      end
      return nx;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n_m  <= 0;
         ms_a <= A_RST;
         mp_a <= A_RST;
         ms_b <= {1'b0, B_RST};
         mp_b <= {1'b0, B_RST};
      end else begin
         n_m <= n_m + 1;
         log_a[(n_m + 1) % LOGN] <= ain_a;
         log_b[(n_m + 1) % LOGN] <= {1'b0, ain_b};
         mp_a <= ms_a;
         mp_b <= ms_b;
`ifdef SYNC_FILTER_EN
         ms_a <= filt_next(1'b0, ms_a);
         ms_b <= filt_next(1'b1, ms_b);
`else
         ms_a <= tail_of(1'b0, n_m + 1);
         ms_b <= tail_of(1'b1, n_m + 1);
`endif
      end
   end

   // ------------------------------------------------------------------
   // Comparison helpers
   // ------------------------------------------------------------------
   task automatic chk_a(input string nm, input logic [3:0] es, input logic [3:0] er, input logic [3:0] ef);
      logic ea;
      ea = |(er | ef);
      checks++;
      if (sync_a !== es || rise_a !== er || fall_a !== ef || any_a !== ea) begin
         errors++;
         $display("FAIL %s (A): got sync=%b rise=%b fall=%b any=%b, want sync=%b rise=%b fall=%b any=%b",
                  nm, sync_a, rise_a, fall_a, any_a, es, er, ef, ea);
      end
   endtask

   task automatic chk_b(input string nm, input logic [2:0] es, input logic [2:0] er, input logic [2:0] ef);
      logic ea;
      ea = |(er | ef);
      checks++;
      if (sync_b !== es || rise_b !== er || fall_b !== ef || any_b !== ea) begin
         errors++;
         $display("FAIL %s (B): got sync=%b rise=%b fall=%b any=%b, want sync=%b rise=%b fall=%b any=%b",
                  nm, sync_b, rise_b, fall_b, any_b, es, er, ef, ea);
      end
   endtask

   task automatic chk_model(input string nm);
      chk_a(nm, ms_a, ms_a & ~mp_a, ~ms_a & mp_a);
      chk_b(nm, ms_b[2:0], ms_b[2:0] & ~mp_b[2:0], ~ms_b[2:0] & mp_b[2:0]);
   endtask

   task automatic do_reset(input logic [3:0] a, input logic [2:0] b);
      @(negedge clk);
      rst   = 1'b1;
      ain_a = a;
      ain_b = b;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic settle(input logic [3:0] a);
      ain_a = a;
      repeat (LAT_A + 2) @(negedge clk);
   endtask

   function automatic logic toggle_at(input int k);
      return (((k - 1) / 3) % 2) == 0;
   endfunction

   typedef struct {
      logic [3:0] ain;
      logic [3:0] es;
      logic [3:0] er;
      logic [3:0] ef;
   } vec_t;

   vec_t       tv [NVEC];
   logic [3:0] pat [6];

   initial begin
      logic [3:0] cur, prv, ex;
      int         emax;
      checks = 0;
      errors = 0;

      // Vector table: each level held 4 cycles, expected output is the same
      // sequence delayed by the total latency.
      pat[0] = 4'b1000; pat[1] = 4'b0101; pat[2] = 4'b1111;
      pat[3] = 4'b0000; pat[4] = 4'b1010; pat[5] = 4'b0110;
      for (int i = 0; i < NVEC; i++) tv[i].ain = pat[i / 4];
      for (int i = 0; i < NVEC; i++) begin
         cur = (i - LAT_A + 1 >= 0) ? tv[i - LAT_A + 1].ain : A_RST;
         prv = (i - LAT_A >= 0)     ? tv[i - LAT_A].ain     : A_RST;
         tv[i].es = cur;
         tv[i].er = cur & ~prv;
         tv[i].ef = ~cur & prv;
      end

      // ---- Test 1: reset with inputs high, then release ----
      rst   = 1'b1;
      ain_a = 4'hF;
      ain_b = 3'b111;
      repeat (2) begin
         @(negedge clk);
         chk_a("reset_hold", A_RST, 4'h0, 4'h0);
         chk_b("reset_hold", B_RST, 3'b000, 3'b000);
      end
      rst  = 1'b0;
      emax = (LAT_A > LAT_B ? LAT_A : LAT_B) + 1;
      for (int e = 1; e <= emax; e++) begin
         @(negedge clk);
         chk_a("release_fill", (e >= LAT_A) ? 4'hF : 4'h0, (e == LAT_A) ? 4'hF : 4'h0, 4'h0);
         chk_b("release_fill", (e >= LAT_B) ? 3'b111 : B_RST, (e == LAT_B) ? 3'b010 : 3'b000, 3'b000);
      end

      // ---- Table-driven vectors from a fresh reset ----
      do_reset(4'h0, B_RST);
      for (int i = 0; i < NVEC; i++) begin
         ain_a = tv[i].ain;
         @(negedge clk);
         chk_a("table", tv[i].es, tv[i].er, tv[i].ef);
      end

      // ---- Test 4: simultaneous rises and fall ----
      settle(4'b1000);
      ain_a = 4'b0101;
      for (int e = 1; e <= LAT_A + 1; e++) begin
         @(negedge clk);
         chk_a("simultaneous", (e >= LAT_A) ? 4'b0101 : 4'b1000,
               (e == LAT_A) ? 4'b0101 : 4'b0000, (e == LAT_A) ? 4'b1000 : 4'b0000);
      end

      // ---- Test 3: short excursion on channel 1, then a sustained rise ----
      settle(4'h0);
`ifdef SYNC_FILTER_EN
      for (int e = 1; e <= LAT_A + 6; e++) begin
         ain_a = (e <= 3) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         chk_a("glitch_reject", 4'h0, 4'h0, 4'h0);
      end
`else
      for (int e = 1; e <= LAT_A + 2; e++) begin
         ain_a = (e == 1) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         chk_a("glitch_pass", (e == LAT_A) ? 4'b0010 : 4'b0000,
               (e == LAT_A) ? 4'b0010 : 4'b0000, (e == LAT_A + 1) ? 4'b0010 : 4'b0000);
      end
`endif
      ain_a = 4'b0010;
      for (int e = 1; e <= LAT_A + 2; e++) begin
         @(negedge clk);
         chk_a("sustained_rise", (e >= LAT_A) ? 4'b0010 : 4'b0000, (e == LAT_A) ? 4'b0010 : 4'b0000, 4'h0);
      end

      // ---- Test 6: channel 0 toggles every 3 cycles ----
      settle(4'h0);
      prv = 4'h0;
      for (int e = 1; e <= 18; e++) begin
         ain_a = {3'b000, toggle_at(e)};
         @(negedge clk);
`ifdef SYNC_FILTER_EN
         cur = 4'h0;
`else
         cur = (e - LAT_A + 1 >= 1) ? {3'b000, toggle_at(e - LAT_A + 1)} : 4'h0;
`endif
         chk_a("toggle", cur, cur & ~prv, ~cur & prv);
         prv = cur;
      end

      // ---- Test 5a: asynchronous reset from a settled high state ----
      settle(4'hF);
      chk_a("pre_async_rst", 4'hF, 4'h0, 4'h0);
      #2 rst = 1'b1;
      #1;
      chk_a("async_rst", A_RST, 4'h0, 4'h0);
      chk_b("async_rst", B_RST, 3'b000, 3'b000);
      @(negedge clk);
      ain_a = 4'h0;
      rst   = 1'b0;

      // ---- Test 5b: reset with a value only partway through ----
      settle(4'h0);
      ain_a = 4'hF;
`ifdef SYNC_FILTER_EN
      repeat (A_ST + 2) @(negedge clk);
`else
      repeat (1) @(negedge clk);
`endif
      ain_a = 4'h0;
      #2 rst = 1'b1;
      #1;
      chk_a("midflight_rst", A_RST, 4'h0, 4'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= LAT_A + 3; e++) begin
         @(negedge clk);
         chk_a("no_stale", A_RST, 4'h0, 4'h0);
      end

      // ---- Randomised run against the reference model ----
      do_reset(4'h0, B_RST);
      for (int cyc = 0; cyc < 400; cyc++) begin
         chk_model("random");
         ex = ain_a;
         for (int c = 0; c < 4; c++) if ($urandom_range(0, 3) == 0) ex[c] = ~ex[c];
         ain_a = ex;
         for (int c = 0; c < 3; c++) if ($urandom_range(0, 3) == 0) ain_b[c] = ~ain_b[c];
         if (cyc == 200) begin
            #2 rst = 1'b1;
            #1;
            chk_model("random_rst");
            @(negedge clk);
            rst = 1'b0;
         end
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sync_bank.md
Name: sync_bank

Overview:
- Parametrised multi-channel synchronizer bank. It is the successor to the existing fixed two-flop pointer synchronizer.
- Each channel brings an asynchronous single-bit level into the clk domain through a STAGES-deep flop chain.
- Each channel optionally passes through a stability (glitch) filter.
- Each channel produces a registered level plus single-cycle rise and fall pulses.
- Used for control strobes, enables and status bits that cross into the system clock domain ahead of the UART/ALU control logic.

Parameters:
- CHANNELS, 4: number of independent single-bit channels, minimum 1.
- STAGES, 2: synchronizer flops per channel, minimum 2. Elaboration error if less than 2.
- RST_VAL, {CHANNELS{1'b0}}: per-channel reset value of every chain flop, the filter output and the edge-history flop.
- FILTER_LEN, 4: consecutive stable cycles required before a filtered output changes, minimum 1. Used only when SYNC_FILTER_EN is defined.

Ports:
- clk, input, 1: destination-domain clock. All flops are rising-edge.
- rst, input, 1: asynchronous, active-high reset. Asserted, it forces all state to reset values immediately; release is synchronous to clk.
- async_in, input, CHANNELS: asynchronous levels, one per channel.
- sync_out, output, CHANNELS: synchronized (and filtered when enabled) level, registered.
- rise_pulse, output, CHANNELS: one-cycle high when the corresponding sync_out goes 0->1.
- fall_pulse, output, CHANNELS: one-cycle high when the corresponding sync_out goes 1->0.
- any_edge, output, 1: OR of all rise_pulse and fall_pulse bits.

Behaviour:
- Reset, while rst=1:
  - All chain flops, filter outputs and history flops equal RST_VAL.
  - Filter counters equal 0.
  - sync_out equals RST_VAL; rise_pulse, fall_pulse and any_edge are 0.
  - No pulse is generated on the first cycle after reset release.
- Chain:
  - stage[0] <= async_in each edge; stage[i] <= stage[i-1].
  - The tail is stage[STAGES-1].
  - Channels are fully independent; no cross-channel coherency is guaranteed. Multi-bit buses must be Gray-coded by the source.
- Without the filter: sync_out = tail. A change held on async_in before edge k appears on sync_out after edge k+STAGES-1, i.e. latency STAGES edges.
- Filter, per channel:
  - State: registered filt and a counter cnt of width $clog2(FILTER_LEN+1).
  - If tail == filt: cnt <= 0.
  - Else if cnt == FILTER_LEN-1: filt <= tail and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Latency is STAGES+FILTER_LEN edges.
  - A tail excursion shorter than FILTER_LEN cycles never reaches sync_out; the counter restarts from 0 when tail returns to filt.
  - FILTER_LEN=1 adds exactly one register stage.
- Edge detect:
  - hist <= sync_out each edge.
  - rise_pulse = sync_out & ~hist; fall_pulse = ~sync_out & hist. Both are combinational from registers, so glitch-free.
  - A pulse is high in the first cycle sync_out holds its new value, for exactly one cycle.
  - Back-to-back toggles of sync_out give alternating rise/fall pulses on consecutive cycles.
- Simultaneous events: multiple channels changing on the same edge each produce their own pulse in the same cycle; any_edge is 1 for that cycle.
- Reset mid-operation: in-flight values and partial counts are discarded. Outputs return to reset values in the same cycle rst rises, with no pulse.

Optional Feature:
- SYNC_FILTER_EN defined: the stability filter per channel is instantiated, and latency is STAGES+FILTER_LEN.
- Not defined: no filter logic and no counters; sync_out = tail, and latency is STAGES. FILTER_LEN is ignored.

Test Plan:
1. Reset with async_in=4'hF and RST_VAL=0; release rst -> sync_out=0 and no pulses during reset or on the first post-release cycle. sync_out=4'hF after 2 edges (no filter), with rise_pulse=4'hF for one cycle and any_edge=1.
2. Filter off, STAGES=3: set async_in[0] 0->1 before edge 1 -> sync_out[0]=1 after edge 3. rise_pulse[0]=1 only in the cycle after edge 3; fall_pulse stays 0.
3. SYNC_FILTER_EN, FILTER_LEN=4: 3-cycle high glitch on async_in[1] -> sync_out[1] stays 0 with no pulses. A 4-cycle-plus high on async_in[1] -> sync_out[1]=1 after 2+4 edges, with a single rise_pulse[1].
4. Channels 0 and 2 rise while channel 3 falls on the same edge -> rise_pulse=4'b0101 and fall_pulse=4'b1000 in the same cycle, any_edge=1 for one cycle only.
5. Assert rst asynchronously mid-chain (value in stage[0] only, filter cnt=2) -> immediate sync_out=RST_VAL and cnt=0. After release, no stale value emerges and no pulse fires.
6. Toggle async_in[0] every 3 cycles with the filter off -> alternating rise_pulse[0] and fall_pulse[0], each exactly one cycle, spaced 3 cycles apart.
